// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
//
// Purpose:
//   Drives four LEDs with PWM from a 4-bit LED pattern. A lit input bit holds
//   its channel at full brightness. Once the bit drops, the channel's duty
//   decays by DECAY_STEP every FADE_PERIODS PWM periods, so a rotating
//   one-hot pattern leaves a fading trail. A one-cycle pulse at the start of
//   every PWM period is offered upstream as a step enable.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset (overrides en)
//   en           block enable; low freezes all counters and blanks the outputs
//   led_in[3:0]  LED pattern from upstream (any combination of bits is legal)
//   led_out[3:0] PWM-modulated LED drive, registered
//   period_tick  one-cycle pulse while cnt==0, registered
//
// Parameters:
//   PWM_BITS     width of the PWM counter and duty registers (MAX = 2^PWM_BITS-1)
//   FADE_PERIODS PWM periods between decay steps (>= 1)
//   DECAY_STEP   amount removed from a duty on each decay step (1..MAX)
// -----------------------------------------------------------------------------
module led_pwm_fader #(
  parameter int PWM_BITS     = 8,
  parameter int FADE_PERIODS = 16,
  parameter int DECAY_STEP   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic       period_tick
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  // A single-period prescaler still needs a 1-bit register to stay legal.
  localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] DECAY     = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] cnt;
  logic [FW-1:0]       fcnt;
  logic [PWM_BITS-1:0] duty        [4];
  logic [PWM_BITS-1:0] active_duty [4];

  logic                wrap;
  logic                fade_step;
  logic [PWM_BITS-1:0] duty_next   [4];
  logic [3:0]          pwm_next;

  always_comb begin
    wrap      = (cnt == MAX);
    fade_step = wrap && (fcnt == FADE_LAST);
    for (int i = 0; i < 4; i++) begin
      duty_next[i] = duty[i];
      // A lit input outranks a decay step landing on the same edge.
      if (led_in[i]) begin
        duty_next[i] = MAX;
      end else if (fade_step) begin
        // Saturate at zero rather than wrapping back to a bright value.
        duty_next[i] = (duty[i] > DECAY) ? (duty[i] - DECAY) : '0;
      end
      pwm_next[i] = (cnt < active_duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      fcnt        <= '0;
      led_out     <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        duty[i]        <= '0;
        active_duty[i] <= '0;
      end
    end else if (en) begin
      cnt         <= cnt + 1'b1;
      period_tick <= wrap;
      led_out     <= pwm_next;
      if (wrap) begin
        fcnt <= fade_step ? '0 : (fcnt + 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
        duty[i] <= duty_next[i];
        // The compare only ever sees a duty latched at a period boundary,
        // so a mid-period duty change cannot produce a runt pulse.
        if (wrap) begin
          active_duty[i] <= duty[i];
        end
      end
    end else begin
      led_out     <= '0;
      period_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
//
// Self-checking bench for led_pwm_fader with PWM_BITS=4 (MAX=15),
// FADE_PERIODS=2, DECAY_STEP=4. A behavioural model tracks the position in
// the PWM period, the number of completed periods since reset, and per-channel
// brightness as plain integers.
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

  localparam int MAXV = 15;
  localparam int PER  = 16;
  localparam int FP   = 2;
  localparam int DS   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] led_in;
  logic [3:0] led_out;
  logic       period_tick;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PWM_BITS    (4),
    .FADE_PERIODS(FP),
    .DECAY_STEP  (DS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .led_in     (led_in),
    .led_out    (led_out),
    .period_tick(period_tick)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- behavioural reference model ----------------
  int         m_phase;   // cycles elapsed in the current PWM period
  int         m_wraps;   // PWM periods completed since reset
  int         m_duty [4];
  int         m_show [4]; // brightness in force for the current period
  logic [3:0] m_led;
  logic       m_tick;

  function automatic void model_step(input logic rst, input logic e, input logic [3:0] li);
    logic [3:0] nl;
    logic       period_end;
    logic       fade;
    nl   = '0;
    fade = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_wraps = 0;
      for (int i = 0; i < 4; i++) begin
        m_duty[i] = 0;
        m_show[i] = 0;
      end
      m_led  = '0;
      m_tick = 1'b0;
    end else if (!e) begin
      m_led  = '0;
      m_tick = 1'b0;
    end else begin
      period_end = (m_phase == PER - 1);
      for (int i = 0; i < 4; i++) nl[i] = (m_phase < m_show[i]);
      if (period_end) begin
        m_wraps = m_wraps + 1;
        fade    = ((m_wraps % FP) == 0);
        for (int i = 0; i < 4; i++) m_show[i] = m_duty[i];
      end
      for (int i = 0; i < 4; i++) begin
        if (li[i])     m_duty[i] = MAXV;
        else if (fade) m_duty[i] = (m_duty[i] > DS) ? m_duty[i] - DS : 0;
      end
      m_led   = nl;
      m_tick  = period_end;
      m_phase = (m_phase + 1) % PER;
    end
  endfunction

  // ---------------- clocking / accumulation ----------------
  int         w_hi [4];
  int         w_ticks;
  logic       w_last_tick;
  logic [3:0] w_led_any;

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) w_hi[i] = 0;
    w_ticks     = 0;
    w_last_tick = 1'b0;
    w_led_any   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(reset, en, led_in);
    #1;
    for (int i = 0; i < 4; i++) if (led_out[i]) w_hi[i]++;
    if (period_tick) w_ticks++;
    w_last_tick = period_tick;
    w_led_any   = w_led_any | led_out;
  endtask

  task automatic run_cycles(input int n);
    clear_acc();
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    en     = 1'b1;
    led_in = '0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic got;
    do_reset();
    led_in = 4'b1111;
    run_cycles(20);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if (led_out !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_led cycle %0d: got %b expected 0000", k, led_out);
      end
      tests_run++;
      if (period_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_tick cycle %0d: got %b expected 0", k, period_tick);
      end
    end
    reset = 1'b0;
    clear_acc();
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (period_tick === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got || n != 16) begin
      tests_failed++;
      $display("FAIL reset_first_tick: got %0d cycles (seen=%b) expected 16", n, got);
    end
    tests_run++;
    if (w_led_any !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_first_period_dark: got %b expected 0000", w_led_any);
    end
  endtask

  task automatic test_steady_on();
    do_reset();
    led_in = 4'b0001;
    run_cycles(16);
    tests_run++;
    if (w_ticks != 1 || w_last_tick !== 1'b1 || w_led_any !== 4'b0000) begin
      tests_failed++;
      $display("FAIL steady_first_period: got ticks=%0d last=%b leds=%b expected 1 1 0000",
               w_ticks, w_last_tick, w_led_any);
    end
    for (int p = 0; p < 3; p++) begin
      run_cycles(16);
      tests_run++;
      if (w_hi[0] != 15) begin
        tests_failed++;
        $display("FAIL steady_duty p%0d: got %0d high cycles expected 15", p, w_hi[0]);
      end
      tests_run++;
      if (w_led_any[3:1] !== 3'b000) begin
        tests_failed++;
        $display("FAIL steady_other p%0d: got %b expected 000", p, w_led_any[3:1]);
      end
      tests_run++;
      if (w_ticks != 1 || w_last_tick !== 1'b1) begin
        tests_failed++;
        $display("FAIL steady_tick p%0d: got ticks=%0d last=%b expected 1 1", p, w_ticks, w_last_tick);
      end
    end
  endtask

  task automatic test_fade();
    int exp_hi [12] = '{15, 15, 15, 11, 11, 7, 7, 3, 3, 0, 0, 0};
    do_reset();
    led_in = 4'b0001;
    run_cycles(32);
    led_in = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      run_cycles(16);
      tests_run++;
      if (w_hi[0] != exp_hi[k]) begin
        tests_failed++;
        $display("FAIL fade period %0d: got %0d high cycles expected %0d", k + 3, w_hi[0], exp_hi[k]);
      end
    end
  endtask

  task automatic test_priority();
    int exp_hi [4] = '{0, 15, 15, 11};
    do_reset();
    run_cycles(31);
    // Lit only for the edge that also carries a decay step.
    led_in = 4'b0100;
    cyc();
    led_in = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      run_cycles(16);
      tests_run++;
      if (w_hi[2] != exp_hi[k] || w_led_any[1:0] !== 2'b00 || w_led_any[3] !== 1'b0) begin
        tests_failed++;
        $display("FAIL priority period %0d: got ch2=%0d leds=%b expected ch2=%0d others 0",
                 k + 3, w_hi[2], w_led_any, exp_hi[k]);
      end
    end
  endtask

  task automatic test_enable();
    int n;
    logic got;
    do_reset();
    led_in = 4'b0001;
    run_cycles(37);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      tests_run++;
      if (led_out !== 4'b0000 || period_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL enable_blank cycle %0d: got led=%b tick=%b expected 0000 0", k, led_out, period_tick);
      end
    end
    en  = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      cyc();
      n++;
      if (period_tick === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got || n != 11) begin
      tests_failed++;
      $display("FAIL enable_resume_tick: got %0d cycles (seen=%b) expected 11", n, got);
    end
    run_cycles(16);
    tests_run++;
    if (w_hi[0] != 15) begin
      tests_failed++;
      $display("FAIL enable_duty_held: got %0d high cycles expected 15", w_hi[0]);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < 4; ch++) begin
        led_in = 4'b0001 << ch;
        for (int p = 0; p < 4; p++) begin
          clear_acc();
          for (int c = 0; c < 16; c++) begin
            cyc();
            tests_run++;
            if (led_out !== m_led || period_tick !== m_tick) begin
              tests_failed++;
              $display("FAIL rotation_model r%0d ch%0d p%0d c%0d: got led=%b tick=%b expected led=%b tick=%b",
                       r, ch, p, c, led_out, period_tick, m_led, m_tick);
            end
          end
          if (p >= 1) begin
            tests_run++;
            if (w_hi[ch] != 15) begin
              tests_failed++;
              $display("FAIL rotation_lit r%0d ch%0d p%0d: got %0d expected 15", r, ch, p, w_hi[ch]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) led_in = 4'($urandom_range(0, 15));
      cyc();
      tests_run++;
      if (led_out !== m_led || period_tick !== m_tick) begin
        tests_failed++;
        $display("FAIL random_model c%0d: got led=%b tick=%b expected led=%b tick=%b",
                 c, led_out, period_tick, m_led, m_tick);
      end
    end
    reset = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    led_in = '0;
    clear_acc();
    test_reset();
    test_steady_on();
    test_fade();
    test_priority();
    test_enable();
    test_rotation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
